// File: rtl/strm_responder.sv
// AXI4 slave standing in for host memory in the stream test harness: serves
// credit words from two pools, returns patterned read bursts, checks write bursts.
module strm_responder #(
  parameter int ID_W     = 16,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int CRED_W   = 32,
  parameter int CRED_MAX = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   cfg_r_cred_addr,
  input  logic [ADDR_W-1:0]   cfg_w_cred_addr,
  input  logic                cfg_load,
  input  logic [CRED_W-1:0]   cfg_r_pool,
  input  logic [CRED_W-1:0]   cfg_w_pool,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  output logic [63:0]         stat_rd_beats,
  output logic [63:0]         stat_wr_beats,
  output logic [31:0]         stat_err
);

  localparam int LANES = DATA_W / 32;
  localparam logic [CRED_W-1:0] CRED_LIM = CRED_W'(CRED_MAX);
  localparam logic [2:0] FULL_SIZE = 3'b110;

  typedef enum logic [1:0] {R_IDLE, R_CRED, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t          r_state_reg;
  logic              arready_reg, rvalid_reg, cred_sel_reg;
  logic [ID_W-1:0]   rid_reg;
  logic [7:0]        rlen_reg, rbeat_reg;
  logic [CRED_W-1:0] cred_g_reg, r_pool_reg, w_pool_reg;

  w_state_t          w_state_reg;
  logic              awready_reg, wready_reg, bvalid_reg, wbad_reg;
  logic [ID_W-1:0]   bid_reg;
  logic [7:0]        wlen_reg, wbeat_reg;
  logic [1:0]        bresp_reg;

  logic [63:0]       rd_beats_reg, wr_beats_reg;
  logic [31:0]       err_reg;

  logic [DATA_W-1:0] r_pat, w_pat;

  // Every 32-bit lane of a data beat carries its beat index.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign r_pat[gi*32 +: 32] = 32'(rbeat_reg);
      assign w_pat[gi*32 +: 32] = 32'(wbeat_reg);
    end
  endgenerate

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic ar_cred, ar_rsel, w_err, w_end, w_at_len;
  logic [CRED_W-1:0] pick_pool, grant, take_pool;
  logic [2:0]  err_inc;
  logic [32:0] err_sum;
  logic        unused_bits;

  assign ar_hs = s_arvalid && arready_reg;
  assign r_hs  = rvalid_reg && s_rready;
  assign aw_hs = s_awvalid && awready_reg;
  assign w_hs  = s_wvalid && wready_reg;
  assign b_hs  = bvalid_reg && s_bready;

  // The read-credit address takes priority when both cfg addresses match.
  assign ar_rsel   = (s_araddr == cfg_r_cred_addr);
  assign ar_cred   = ar_rsel || (s_araddr == cfg_w_cred_addr);
  assign pick_pool = ar_rsel ? r_pool_reg : w_pool_reg;
  assign grant     = (pick_pool > CRED_LIM) ? CRED_LIM : pick_pool;
  assign take_pool = cred_sel_reg ? r_pool_reg : w_pool_reg;

  assign w_at_len = (wbeat_reg == wlen_reg);
  assign w_end    = s_wlast || w_at_len;
  assign w_err    = (s_wdata != w_pat) || (s_wstrb != '1) || (s_wlast != w_at_len);

  assign err_inc = 3'(ar_hs && (s_arsize != FULL_SIZE))
                 + 3'(ar_hs && ar_cred && (s_arlen != 8'd0))
                 + 3'(aw_hs && (s_awsize != FULL_SIZE))
                 + 3'(w_hs && w_err);
  assign err_sum = {1'b0, err_reg} + 33'(err_inc);

  assign unused_bits = ^s_awaddr;

  assign s_arready = arready_reg;
  assign s_rvalid  = rvalid_reg;
  assign s_rid     = rid_reg;
  assign s_rresp   = 2'b00;
  assign s_rlast   = (r_state_reg == R_CRED) || (rbeat_reg == rlen_reg);
  assign s_rdata   = (r_state_reg == R_CRED) ? {{(DATA_W-CRED_W){1'b0}}, cred_g_reg} : r_pat;
  assign s_awready = awready_reg;
  assign s_wready  = wready_reg;
  assign s_bvalid  = bvalid_reg;
  assign s_bid     = bid_reg;
  assign s_bresp   = bresp_reg;
  assign stat_rd_beats = rd_beats_reg;
  assign stat_wr_beats = wr_beats_reg;
  assign stat_err      = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_reg  <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      cred_sel_reg <= 1'b0;
      rid_reg      <= '0;
      rlen_reg     <= '0;
      rbeat_reg    <= '0;
      cred_g_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          arready_reg <= 1'b1;
          if (ar_hs) begin
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b1;
            rid_reg      <= s_arid;
            rlen_reg     <= s_arlen;
            rbeat_reg    <= '0;
            cred_g_reg   <= grant;
            cred_sel_reg <= ar_rsel;
            r_state_reg  <= ar_cred ? R_CRED : R_DATA;
          end
        end
        R_CRED: begin
          if (r_hs) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rbeat_reg == rlen_reg) begin
              rvalid_reg  <= 1'b0;
              arready_reg <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              rbeat_reg <= rbeat_reg + 8'd1;
            end
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  // A reload can shrink a pool below the grant already latched, so the take saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pool_reg <= '0;
      w_pool_reg <= '0;
    end else if (cfg_load) begin
      r_pool_reg <= cfg_r_pool;
      w_pool_reg <= cfg_w_pool;
    end else if (r_hs && (r_state_reg == R_CRED)) begin
      if (cred_sel_reg)
        r_pool_reg <= r_pool_reg - ((cred_g_reg > take_pool) ? take_pool : cred_g_reg);
      else
        w_pool_reg <= w_pool_reg - ((cred_g_reg > take_pool) ? take_pool : cred_g_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      wbad_reg    <= 1'b0;
      bid_reg     <= '0;
      wlen_reg    <= '0;
      wbeat_reg   <= '0;
      bresp_reg   <= 2'b00;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          awready_reg <= 1'b1;
          if (aw_hs) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b1;
            bid_reg     <= s_awid;
            wlen_reg    <= s_awlen;
            wbeat_reg   <= '0;
            wbad_reg    <= 1'b0;
            w_state_reg <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_end) begin
              wready_reg  <= 1'b0;
              bvalid_reg  <= 1'b1;
              bresp_reg   <= (wbad_reg || w_err) ? 2'b10 : 2'b00;
              w_state_reg <= W_RESP;
            end else begin
              wbeat_reg <= wbeat_reg + 8'd1;
              wbad_reg  <= wbad_reg || w_err;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_beats_reg <= '0;
      wr_beats_reg <= '0;
      err_reg      <= '0;
    end else begin
      rd_beats_reg <= rd_beats_reg + 64'(r_hs);
      wr_beats_reg <= wr_beats_reg + 64'(w_hs);
      err_reg      <= err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end
  end

endmodule

// File: tb/tb_strm_responder.sv
// Directed bench for strm_responder: credit pools, patterned reads, write
// checking, error counting and asynchronous reset in the middle of bursts.
module tb_strm_responder;

  localparam logic [63:0] R_ADDR = 64'h1000;
  localparam logic [63:0] W_ADDR = 64'h2000;

  logic         clk, rst_n;
  logic [63:0]  cfg_r_cred_addr, cfg_w_cred_addr;
  logic         cfg_load;
  logic [31:0]  cfg_r_pool, cfg_w_pool;
  logic [15:0]  s_arid, s_rid, s_awid, s_bid;
  logic [63:0]  s_araddr, s_awaddr;
  logic [7:0]   s_arlen, s_awlen;
  logic [2:0]   s_arsize, s_awsize;
  logic         s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [511:0] s_rdata, s_wdata;
  logic [1:0]   s_rresp, s_bresp;
  logic         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [63:0]  s_wstrb;
  logic         s_bvalid, s_bready;
  logic [63:0]  stat_rd_beats, stat_wr_beats;
  logic [31:0]  stat_err;

  int checks = 0;
  int errors = 0;

  strm_responder dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_r_cred_addr(cfg_r_cred_addr), .cfg_w_cred_addr(cfg_w_cred_addr),
    .cfg_load(cfg_load), .cfg_r_pool(cfg_r_pool), .cfg_w_pool(cfg_w_pool),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats), .stat_err(stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int k);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [15:0] id, input logic [63:0] addr,
                         input logic [7:0] len, input logic [2:0] size);
    bit pend = 1;
    s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arvalid = 1'b1;
    for (int n = 0; n < 50 && pend; n++) begin
      if (s_arready) pend = 0;
      tick();
    end
    s_arvalid = 1'b0;
    if (pend) begin errors++; $display("FAIL ar_timeout addr=%0h", addr); end
  endtask

  task automatic recv_r(output logic [511:0] d, output logic last, output logic [15:0] id);
    bit pend = 1;
    d = '0; last = 1'b0; id = '0;
    s_rready = 1'b1;
    for (int n = 0; n < 50 && pend; n++) begin
      if (s_rvalid) begin
        d = s_rdata; last = s_rlast; id = s_rid; pend = 0;
      end
      tick();
    end
    s_rready = 1'b0;
    if (pend) begin errors++; $display("FAIL r_timeout"); end
  endtask

  task automatic cred_read(input logic [63:0] addr, input logic [7:0] len,
                           output logic [31:0] val, output logic last);
    logic [511:0] d;
    logic [15:0]  id;
    send_ar(16'h00C0, addr, len, 3'b110);
    recv_r(d, last, id);
    val = d[31:0];
  endtask

  task automatic send_aw(input logic [15:0] id, input logic [7:0] len);
    bit pend = 1;
    s_awid = id; s_awaddr = 64'h9000; s_awlen = len; s_awsize = 3'b110; s_awvalid = 1'b1;
    for (int n = 0; n < 50 && pend; n++) begin
      if (s_awready) pend = 0;
      tick();
    end
    s_awvalid = 1'b0;
    if (pend) begin errors++; $display("FAIL aw_timeout"); end
  endtask

  task automatic send_w(input logic [511:0] d, input logic last);
    bit pend = 1;
    s_wdata = d; s_wstrb = '1; s_wlast = last; s_wvalid = 1'b1;
    for (int n = 0; n < 50 && pend; n++) begin
      if (s_wready) pend = 0;
      tick();
    end
    s_wvalid = 1'b0;
    if (pend) begin errors++; $display("FAIL w_timeout"); end
  endtask

  task automatic recv_b(output logic [15:0] id, output logic [1:0] resp);
    bit pend = 1;
    id = '0; resp = 2'b11;
    s_bready = 1'b1;
    for (int n = 0; n < 50 && pend; n++) begin
      if (s_bvalid) begin id = s_bid; resp = s_bresp; pend = 0; end
      tick();
    end
    s_bready = 1'b0;
    if (pend) begin errors++; $display("FAIL b_timeout"); end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b exp 00000",
                         {s_arready, s_rvalid, s_awready, s_wready, s_bvalid});
    end
    checks++;
    if ({stat_rd_beats, stat_wr_beats, stat_err} !== 160'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d/%0d exp 0/0/0",
                         stat_rd_beats, stat_wr_beats, stat_err);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({s_arready, s_awready, s_wready} !== 3'b110) begin
      errors++; $display("FAIL idle_ready got %b exp 110", {s_arready, s_awready, s_wready});
    end
    $display("test_reset done");
  endtask

  task automatic test_credit_pool();
    int exp_g[3] = '{64, 36, 0};
    logic [31:0] v;
    logic last;
    cfg_r_pool = 32'd100; cfg_w_pool = 32'd0; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cred_read(R_ADDR, 8'd0, v, last);
      checks++;
      if (v !== 32'(exp_g[i]) || last !== 1'b1) begin
        errors++; $display("FAIL cred_read%0d got %0d last %b exp %0d last 1", i, v, last, exp_g[i]);
      end
      $display("credit read %0d -> %0d", i, v);
    end
    checks++;
    if (stat_rd_beats !== 64'd3) begin
      errors++; $display("FAIL cred_rd_beats got %0d exp 3", stat_rd_beats);
    end
  endtask

  task automatic test_data_read();
    int k = 0;
    send_ar(16'h1234, 64'h8000, 8'd3, 3'b110);
    checks++;
    if (s_rvalid !== 1'b1) begin
      errors++; $display("FAIL rvalid_latency got %b exp 1", s_rvalid);
    end
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      s_rready = cyc[0];
      if (s_rvalid && s_rready) begin
        checks++;
        if (s_rdata !== pat(k) || s_rlast !== (k == 3) || s_rid !== 16'h1234 || s_rresp !== 2'b00) begin
          errors++; $display("FAIL rbeat%0d got lane0=%0h last=%b id=%0h exp lane0=%0h last=%b id=1234",
                             k, s_rdata[31:0], s_rlast, s_rid, k, (k == 3));
        end
        $display("read beat %0d lane0=%0h last=%b", k, s_rdata[31:0], s_rlast);
        k++;
      end
      tick();
    end
    s_rready = 1'b0;
    checks++;
    if (k !== 4 || s_rvalid !== 1'b0) begin
      errors++; $display("FAIL rburst_end got beats=%0d rvalid=%b exp 4 0", k, s_rvalid);
    end
    checks++;
    if (stat_rd_beats !== 64'd7) begin
      errors++; $display("FAIL data_rd_beats got %0d exp 7", stat_rd_beats);
    end
  endtask

  task automatic test_write_good();
    logic [15:0] id;
    logic [1:0]  resp;
    checks++;
    if (s_wready !== 1'b0) begin
      errors++; $display("FAIL wready_before_aw got %b exp 0", s_wready);
    end
    send_aw(16'hBEEF, 8'd7);
    for (int j = 0; j < 8; j++) send_w(pat(j), j == 7);
    recv_b(id, resp);
    $display("write good bid=%0h bresp=%b", id, resp);
    checks++;
    if (id !== 16'hBEEF || resp !== 2'b00) begin
      errors++; $display("FAIL wgood_b got id=%0h resp=%b exp id=beef resp=00", id, resp);
    end
    checks++;
    if (stat_wr_beats !== 64'd8 || stat_err !== 32'd0) begin
      errors++; $display("FAIL wgood_stats got wr=%0d err=%0d exp 8 0", stat_wr_beats, stat_err);
    end
  endtask

  task automatic test_write_bad();
    logic [15:0] id;
    logic [1:0]  resp;
    logic [511:0] bad;
    send_aw(16'h0042, 8'd3);
    bad = pat(0);
    bad[0] = ~bad[0];
    send_w(bad, 1'b0);
    send_w(pat(1), 1'b1);
    checks++;
    if (s_wready !== 1'b0) begin
      errors++; $display("FAIL early_end_wready got %b exp 0", s_wready);
    end
    recv_b(id, resp);
    $display("write bad bid=%0h bresp=%b", id, resp);
    checks++;
    if (id !== 16'h0042 || resp !== 2'b10) begin
      errors++; $display("FAIL wbad_b got id=%0h resp=%b exp id=42 resp=10", id, resp);
    end
    checks++;
    if (stat_wr_beats !== 64'd10 || stat_err !== 32'd2) begin
      errors++; $display("FAIL wbad_stats got wr=%0d err=%0d exp 10 2", stat_wr_beats, stat_err);
    end
  endtask

  task automatic test_cred_edges();
    logic [31:0] v;
    logic [511:0] d;
    logic [15:0] id;
    logic last;
    cfg_r_pool = 32'd5; cfg_w_pool = 32'd7; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    cfg_w_cred_addr = R_ADDR;
    cred_read(R_ADDR, 8'd0, v, last);
    $display("shared addr credit -> %0d", v);
    checks++;
    if (v !== 32'd5) begin
      errors++; $display("FAIL shared_addr got %0d exp 5", v);
    end
    cfg_w_cred_addr = W_ADDR;
    cred_read(W_ADDR, 8'd2, v, last);
    $display("w credit with arlen=2 -> %0d last=%b", v, last);
    checks++;
    if (v !== 32'd7 || last !== 1'b1 || s_rvalid !== 1'b0) begin
      errors++; $display("FAIL cred_len got %0d last %b rvalid %b exp 7 1 0", v, last, s_rvalid);
    end
    send_ar(16'h0005, 64'h8000, 8'd0, 3'b010);
    recv_r(d, last, id);
    checks++;
    if (d !== pat(0) || last !== 1'b1 || id !== 16'h0005) begin
      errors++; $display("FAIL badsize_read got lane0=%0h last %b id %0h exp 0 1 5", d[31:0], last, id);
    end
    checks++;
    if (stat_err !== 32'd4 || stat_rd_beats !== 64'd10) begin
      errors++; $display("FAIL edge_stats got err=%0d rd=%0d exp 4 10", stat_err, stat_rd_beats);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] addrs[2] = '{R_ADDR, W_ADDR};
    logic [31:0] v;
    logic last;
    int sum, n;
    cfg_r_pool = 32'd1000; cfg_w_pool = 32'd1000; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sum = 0; n = 0; v = 32'd1;
      while (n < 25 && v != 0) begin
        cred_read(addrs[p], 8'd0, v, last);
        sum += int'(v);
        n++;
      end
      $display("stream pool %0d credits=%0d reads=%0d", p, sum, n);
      checks++;
      if (sum !== 1000 || n !== 17) begin
        errors++; $display("FAIL stream_pool%0d got sum=%0d reads=%0d exp 1000 17", p, sum, n);
      end
    end
    checks++;
    if (stat_rd_beats !== 64'd44 || stat_err !== 32'd4) begin
      errors++; $display("FAIL stream_stats got rd=%0d err=%0d exp 44 4", stat_rd_beats, stat_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    logic [15:0] id;
    logic [1:0] resp;
    logic [31:0] v;
    logic last;
    send_ar(16'h0007, 64'hA000, 8'd7, 3'b110);
    recv_r(d, last, id);
    recv_r(d, last, id);
    send_aw(16'h0009, 8'd7);
    send_w(pat(0), 1'b0);
    send_w(pat(1), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid} !== 5'b0) begin
      errors++; $display("FAIL midreset_handshake got %b exp 00000",
                         {s_arready, s_rvalid, s_awready, s_wready, s_bvalid});
    end
    checks++;
    if ({stat_rd_beats, stat_wr_beats, stat_err} !== 160'd0) begin
      errors++; $display("FAIL midreset_stats got %0d/%0d/%0d exp 0/0/0",
                         stat_rd_beats, stat_wr_beats, stat_err);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    cred_read(R_ADDR, 8'd0, v, last);
    checks++;
    if (v !== 32'd0) begin
      errors++; $display("FAIL midreset_pool got %0d exp 0", v);
    end
    send_ar(16'h0011, 64'hB000, 8'd1, 3'b110);
    for (int k = 0; k < 2; k++) begin
      recv_r(d, last, id);
      checks++;
      if (d !== pat(k) || last !== (k == 1) || id !== 16'h0011) begin
        errors++; $display("FAIL postreset_rbeat%0d got lane0=%0h last %b id %0h", k, d[31:0], last, id);
      end
    end
    send_aw(16'h0022, 8'd0);
    send_w(pat(0), 1'b1);
    recv_b(id, resp);
    $display("post reset write bid=%0h bresp=%b", id, resp);
    checks++;
    if (id !== 16'h0022 || resp !== 2'b00) begin
      errors++; $display("FAIL postreset_b got id=%0h resp=%b exp 22 00", id, resp);
    end
    checks++;
    if (stat_rd_beats !== 64'd3 || stat_wr_beats !== 64'd1 || stat_err !== 32'd0) begin
      errors++; $display("FAIL postreset_stats got %0d/%0d/%0d exp 3/1/0",
                         stat_rd_beats, stat_wr_beats, stat_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_r_cred_addr = R_ADDR; cfg_w_cred_addr = W_ADDR; cfg_load = 1'b0;
    cfg_r_pool = '0; cfg_w_pool = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'b110; s_arvalid = 1'b0;
    s_rready = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'b110; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    test_reset();
    test_credit_pool();
    test_data_read();
    test_write_good();
    test_write_bad();
    test_cred_edges();
    test_streaming();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
